// File: rtl/calc_pkg.sv
// Shared definitions for the calc_hist calculator: opcodes, FSM states
// and a constant-foldable clog2 helper.
package calc_pkg;

  typedef enum logic [2:0] {
    OP_SRL  = 3'b000,
    OP_SLL  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_MUL  = 3'b100,
    OP_NOR  = 3'b101,
    OP_NAND = 3'b110,
    OP_XOR  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/calc_mul_seq.sv
// Sequential shift-add multiplier: loads on start_i, runs WIDTH iterations,
// and raises done_o during the last one with the final 2*WIDTH product.
module calc_mul_seq
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] prod_o
);

  localparam int unsigned CW = clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand_q, mcand_d, prod_q, prod_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               run_q, run_d;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    if (start_i) begin
      mcand_d  = {{WIDTH{1'b0}}, a_i};
      mplier_d = b_i;
      prod_d   = '0;
      cnt_d    = '0;
      run_d    = 1'b1;
    end else if (run_q) begin
      if (mplier_q[0]) prod_d = prod_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (cnt_q == CW'(WIDTH - 1)) run_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
    end
  end

  // The product handed out includes the final iteration so the parent can commit on that edge.
  assign done_o = run_q && (cnt_q == CW'(WIDTH - 1));
  assign prod_o = prod_d;

endmodule

// File: rtl/calc_hist.sv
// Push-button accumulator calculator with edge-detected buttons, sequential
// multiplier, ovf/zero flags and an undo history built when CALC_HIST_UNDO_EN is defined.
module calc_hist
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned HIST_DEPTH = 8
) (
  input  logic                              clk,
  input  logic                              btnac_n,
  input  logic                              btnc,
  input  logic                              btnu,
  input  logic                              btnl,
  input  logic                              btnr,
  input  logic                              btnd,
  input  logic [WIDTH-1:0]                  sw,
  output logic [WIDTH-1:0]                  led,
  output logic                              busy,
  output logic                              ovf,
  output logic                              zero,
  output logic [clog2(HIST_DEPTH+1)-1:0]    hist_cnt
);

  localparam int unsigned HCW = clog2(HIST_DEPTH + 1);

  state_e             state_q, state_d;
  op_e                op_q, op_d, op_in;
  logic [WIDTH-1:0]   b_q, b_d, acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic               btnc_q, btnu_q, exec_edge, undo_edge;
  logic               mul_start, mul_done, push, pop, undo_ok;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH-1:0]   alu_res, hist_top;
  logic               alu_ovf;
  logic [WIDTH:0]     wide;

  assign exec_edge = btnc & ~btnc_q;
  assign undo_edge = btnu & ~btnu_q;
  assign op_in     = op_e'({btnl, btnr, btnd});

  calc_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (btnac_n),
    .start_i (mul_start),
    .a_i     (acc_q),
    .b_i     (sw),
    .done_o  (mul_done),
    .prod_o  (mul_prod)
  );

  // Shift amounts >= WIDTH yield zero through the shift operators themselves.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    wide    = '0;
    unique case (op_q)
      OP_SRL:  alu_res = acc_q >> b_q;
      OP_SLL:  alu_res = acc_q << b_q;
      OP_ADD: begin
        wide    = {1'b0, acc_q} + {1'b0, b_q};
        alu_res = wide[WIDTH-1:0];
        alu_ovf = wide[WIDTH];
      end
      OP_SUB: begin
        wide    = {1'b0, acc_q} - {1'b0, b_q};
        alu_res = wide[WIDTH-1:0];
        alu_ovf = wide[WIDTH];
      end
      OP_NOR:  alu_res = ~(acc_q | b_q);
      OP_NAND: alu_res = ~(acc_q & b_q);
      OP_XOR:  alu_res = acc_q ^ b_q;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    b_d       = b_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    mul_start = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (exec_edge) begin
          op_d      = op_in;
          b_d       = sw;
          mul_start = (op_in == OP_MUL);
          state_d   = (op_in == OP_MUL) ? MUL : EXEC;
        end else if (undo_edge && undo_ok) begin
          acc_d = hist_top;
          ovf_d = 1'b0;
          pop   = 1'b1;
        end
      end
      EXEC: begin
        acc_d   = alu_res;
        ovf_d   = alu_ovf;
        push    = 1'b1;
        state_d = IDLE;
      end
      MUL: begin
        if (mul_done) begin
          acc_d   = mul_prod[WIDTH-1:0];
          ovf_d   = |mul_prod[2*WIDTH-1:WIDTH];
          push    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge btnac_n) begin
    if (!btnac_n) begin
      state_q <= IDLE;
      op_q    <= OP_SRL;
      b_q     <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      btnc_q  <= 1'b1;
      btnu_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      btnc_q  <= btnc;
      btnu_q  <= btnu;
    end
  end

`ifdef CALC_HIST_UNDO_EN
  localparam int unsigned PW = clog2(HIST_DEPTH);

  logic [WIDTH-1:0] hist_mem_q [HIST_DEPTH];
  logic [PW-1:0]    wr_ptr_q, top_ptr;
  logic [HCW-1:0]   hist_cnt_q;

  // wr_ptr_q points at the next free slot; the newest entry sits just below it.
  assign top_ptr  = (wr_ptr_q == '0) ? PW'(HIST_DEPTH - 1) : wr_ptr_q - PW'(1);
  assign undo_ok  = (hist_cnt_q != '0);
  assign hist_top = hist_mem_q[top_ptr];
  assign hist_cnt = hist_cnt_q;

  always_ff @(posedge clk) begin
    if (push) hist_mem_q[wr_ptr_q] <= acc_q;
  end

  always_ff @(posedge clk or negedge btnac_n) begin
    if (!btnac_n) begin
      wr_ptr_q   <= '0;
      hist_cnt_q <= '0;
    end else if (push) begin
      wr_ptr_q <= (wr_ptr_q == PW'(HIST_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      if (hist_cnt_q != HCW'(HIST_DEPTH)) hist_cnt_q <= hist_cnt_q + HCW'(1);
    end else if (pop) begin
      wr_ptr_q   <= top_ptr;
      hist_cnt_q <= hist_cnt_q - HCW'(1);
    end
  end
`else
  logic unused_hist;

  assign undo_ok     = 1'b0;
  assign hist_top    = '0;
  assign hist_cnt    = '0;
  assign unused_hist = ^{push, pop};
`endif

  assign led  = acc_q;
  assign busy = (state_q != IDLE);
  assign ovf  = ovf_q;
  assign zero = (acc_q == '0);

endmodule

// File: tb/tb_calc_hist.sv
// Randomised and directed bench for calc_hist against an arithmetic/queue reference model.
module tb_calc_hist;

  localparam int W = 16;
  localparam int D = 8;
`ifdef CALC_HIST_UNDO_EN
  localparam bit UNDO_EN = 1'b1;
`else
  localparam bit UNDO_EN = 1'b0;
`endif
  localparam longint MASK = (64'd1 << W) - 1;

  logic         clk = 1'b0;
  logic         btnac_n = 1'b0;
  logic         btnc = 1'b0, btnu = 1'b0, btnl = 1'b0, btnr = 1'b0, btnd = 1'b0;
  logic [W-1:0] sw = '0;
  logic [W-1:0] led;
  logic         busy, ovf, zero;
  logic [3:0]   hist_cnt;

  int checks = 0;
  int errors = 0;
  int m_acc = 0;
  int m_ovf = 0;
  int m_hist[$];

  calc_hist #(.WIDTH(W), .HIST_DEPTH(D)) dut (
    .clk      (clk),
    .btnac_n  (btnac_n),
    .btnc     (btnc),
    .btnu     (btnu),
    .btnl     (btnl),
    .btnr     (btnr),
    .btnd     (btnd),
    .sw       (sw),
    .led      (led),
    .busy     (busy),
    .ovf      (ovf),
    .zero     (zero),
    .hist_cnt (hist_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_cnt();
    return UNDO_EN ? m_hist.size() : 0;
  endfunction

  function automatic void model_exec(input int op, input int b);
    longint a, bb, r;
    int o;
    a = m_acc; bb = b; r = 0; o = 0;
    case (op)
      0: r = (bb >= W) ? 0 : (a >> bb);
      1: r = (bb >= W) ? 0 : (a << bb);
      2: begin r = a + bb; o = (r > MASK) ? 1 : 0; end
      3: begin r = a - bb; o = (bb > a) ? 1 : 0; end
      4: begin r = a * bb; o = (r > MASK) ? 1 : 0; end
      5: r = ~(a | bb);
      6: r = ~(a & bb);
      default: r = a ^ bb;
    endcase
    m_hist.push_back(m_acc);
    if (m_hist.size() > D) void'(m_hist.pop_front());
    m_acc = int'(r & MASK);
    m_ovf = o;
  endfunction

  task automatic do_reset(input bit hold);
    btnac_n = 1'b0;
    btnc = hold; btnu = hold;
    sw = 16'h1234; {btnl, btnr, btnd} = 3'b010;
    #2;
    checks++; if (led !== '0) begin errors++; $display("FAIL rst_led got %h want 0000", led); end
    checks++; if (busy !== 1'b0 || ovf !== 1'b0 || zero !== 1'b1 || hist_cnt !== 4'd0) begin
      errors++; $display("FAIL rst_flags got busy=%b ovf=%b zero=%b cnt=%0d want 0 0 1 0", busy, ovf, zero, hist_cnt);
    end
    @(negedge clk);
    btnac_n = 1'b1;
    repeat (3) tick;
    checks++; if (led !== '0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_held_btn got led=%h busy=%b want 0000 0", led, busy);
    end
    btnc = 1'b0; btnu = 1'b0;
    tick;
    m_acc = 0; m_ovf = 0; m_hist.delete();
  endtask

  task automatic do_exec(input int op, input int b, input bit inject, input bit with_undo);
    int cyc;
    int exp_cyc;
    cyc = 0;
    exp_cyc = (op == 4) ? W : 1;
    {btnl, btnr, btnd} = op[2:0];
    sw = b[W-1:0];
    btnc = 1'b1; btnu = with_undo;
    tick;
    btnc = 1'b0; btnu = 1'b0;
    sw = ~sw; {btnl, btnr, btnd} = 3'b010;
    while (busy === 1'b1 && cyc < 40) begin
      cyc++;
      if (inject && cyc == 3) begin btnc = 1'b1; btnu = 1'b1; end
      else begin btnc = 1'b0; btnu = 1'b0; end
      tick;
    end
    btnc = 1'b0; btnu = 1'b0;
    model_exec(op, b);
    checks++; if (cyc !== exp_cyc) begin
      errors++; $display("FAIL busy_cycles op=%0d got %0d want %0d", op, cyc, exp_cyc);
    end
    checks++; if (led !== m_acc[W-1:0]) begin
      errors++; $display("FAIL exec_led op=%0d b=%h got %h want %h", op, b, led, m_acc[W-1:0]);
    end
    checks++; if (ovf !== m_ovf[0] || zero !== (m_acc == 0)) begin
      errors++; $display("FAIL exec_flags op=%0d got ovf=%b zero=%b want %b %b", op, ovf, zero, m_ovf[0], m_acc == 0);
    end
    checks++; if (hist_cnt !== 4'(exp_cnt())) begin
      errors++; $display("FAIL exec_hist_cnt got %0d want %0d", hist_cnt, exp_cnt());
    end
    tick;
  endtask

  task automatic do_undo;
    btnu = 1'b1;
    tick;
    if (UNDO_EN && m_hist.size() > 0) begin
      m_acc = m_hist.pop_back();
      m_ovf = 0;
    end
    checks++; if (led !== m_acc[W-1:0] || busy !== 1'b0) begin
      errors++; $display("FAIL undo_led got %h busy=%b want %h 0", led, busy, m_acc[W-1:0]);
    end
    checks++; if (ovf !== m_ovf[0] || hist_cnt !== 4'(exp_cnt())) begin
      errors++; $display("FAIL undo_state got ovf=%b cnt=%0d want %b %0d", ovf, hist_cnt, m_ovf[0], exp_cnt());
    end
    btnu = 1'b0;
    tick;
  endtask

  task automatic run_chain;
    do_exec(2, 'h285a, 0, 0);
    do_exec(7, 'h04c8, 0, 0);
    do_exec(0, 5, 0, 0);
    do_exec(5, 'ha085, 0, 0);
  endtask

  task automatic test_reset;
    do_reset(1'b1);
  endtask

  task automatic test_chain;
    run_chain();
    checks++; if (led !== 16'h5e1a || hist_cnt !== (UNDO_EN ? 4'd4 : 4'd0)) begin
      errors++; $display("FAIL chain_end got %h cnt=%0d want 5e1a %0d", led, hist_cnt, UNDO_EN ? 4 : 0);
    end
  endtask

  task automatic test_mul;
    do_exec(4, 'h07fe, 1, 0);
    checks++; if (led !== 16'h13cc || ovf !== 1'b1) begin
      errors++; $display("FAIL mul_result got %h ovf=%b want 13cc 1", led, ovf);
    end
    do_exec(1, 4, 0, 0);
    do_exec(6, 'hfa65, 0, 0);
    do_exec(3, 'hb2e4, 0, 0);
    checks++; if (led !== 16'h14db || ovf !== 1'b0) begin
      errors++; $display("FAIL post_mul_chain got %h ovf=%b want 14db 0", led, ovf);
    end
  endtask

  task automatic test_boundary;
    do_reset(1'b0);
    do_exec(3, 1, 0, 0);
    checks++; if (led !== 16'hffff || ovf !== 1'b1) begin
      errors++; $display("FAIL sub_borrow got %h ovf=%b want ffff 1", led, ovf);
    end
    do_exec(0, 16, 0, 0);
    checks++; if (led !== 16'h0000 || zero !== 1'b1) begin
      errors++; $display("FAIL srl_full got %h zero=%b want 0000 1", led, zero);
    end
    do_exec(2, 'h00f0, 0, 0);
    do_exec(1, 'h8000, 0, 0);
    do_exec(2, 'hffff, 0, 0);
    do_exec(2, 1, 0, 0);
  endtask

  task automatic test_undo;
    do_reset(1'b0);
    run_chain();
    do_undo();
    checks++; if (led !== (UNDO_EN ? 16'h0164 : 16'h5e1a)) begin
      errors++; $display("FAIL undo_first got %h want %h", led, UNDO_EN ? 16'h0164 : 16'h5e1a);
    end
    do_undo();
    checks++; if (led !== (UNDO_EN ? 16'h2c92 : 16'h5e1a) || hist_cnt !== (UNDO_EN ? 4'd2 : 4'd0)) begin
      errors++; $display("FAIL undo_second got %h cnt=%0d", led, hist_cnt);
    end
    repeat (3) do_undo();
    checks++; if (led !== (UNDO_EN ? 16'h0000 : 16'h5e1a) || hist_cnt !== 4'd0) begin
      errors++; $display("FAIL undo_empty got %h cnt=%0d", led, hist_cnt);
    end
  endtask

  task automatic test_wrap;
    do_reset(1'b0);
    repeat (10) do_exec(2, 1, 0, 0);
    checks++; if (hist_cnt !== (UNDO_EN ? 4'd8 : 4'd0)) begin
      errors++; $display("FAIL wrap_cnt got %0d want %0d", hist_cnt, UNDO_EN ? 8 : 0);
    end
    repeat (8) do_undo();
    checks++; if (led !== (UNDO_EN ? 16'd2 : 16'd10)) begin
      errors++; $display("FAIL wrap_undo got %h want %h", led, UNDO_EN ? 16'd2 : 16'd10);
    end
    do_undo();
    checks++; if (led !== (UNDO_EN ? 16'd2 : 16'd10)) begin
      errors++; $display("FAIL wrap_noop got %h", led);
    end
  endtask

  task automatic test_simul;
    do_exec(2, 'h0005, 0, 1);
    do_exec(7, 'h5a5a, 0, 1);
  endtask

  task automatic test_random;
    int r;
    int b;
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      if (r >= 8) begin
        do_undo();
      end else begin
        b = (r <= 1) ? $urandom_range(0, 20) : int'($urandom_range(0, 65535));
        do_exec(r, b, $urandom_range(0, 1), 1'b0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_chain();
    test_mul();
    test_boundary();
    test_undo();
    test_wrap();
    test_simul();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
